// File: rtl/eca_pkg.sv
// Shared constants and pure helper functions for the ECA renderer.
// Rows are carried at MAX_W bits; callers zero-extend and truncate to their own width.
package eca_pkg;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;
    localparam int MAX_W     = 160;

    localparam logic [15:0] LFSR_INIT = 16'hACE1;
    localparam logic [7:0]  RULE_INIT = 8'd30;

    // Bit i of the rule index is {left, self, right}; left is the lower x neighbour.
    function automatic logic [MAX_W-1:0] eca_next(
        input logic [MAX_W-1:0] row,
        input logic [7:0]       rule,
        input logic             wrap,
        input logic [7:0]       w
    );
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] cur;
        logic [MAX_W-1:0] lft;
        logic [MAX_W-1:0] rgt;
        logic [MAX_W-1:0] nxt;
        mask = ~({MAX_W{1'b1}} << w);
        cur  = row & mask;
        lft  = cur << 1;
        lft[0] = wrap & cur[w - 8'd1];
        rgt  = cur >> 1;
        rgt[w - 8'd1] = wrap & cur[0];
        for (int i = 0; i < MAX_W; i++) begin
            nxt[i] = rule[{lft[i], cur[i], rgt[i]}];
        end
        return nxt & mask;
    endfunction

    function automatic logic [MAX_W-1:0] eca_seed_centre(input logic [7:0] w);
        logic [MAX_W-1:0] s;
        s = '0;
        s[w >> 1] = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/eca_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used for random seeds.
import eca_pkg::*;

module eca_lfsr16 (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= LFSR_INIT;
        end else begin
            q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
        end
    end

endmodule

// File: rtl/eca_vga_renderer.sv
// Elementary cellular automaton renderer: one generation per cell row, one pixel per clk.
// Optional macro ECA_SCROLL_EN: frame_row evolves each frame so the image scrolls up.
import eca_pkg::*;

module eca_vga_renderer #(
    parameter int         GRID_W   = 100,
    parameter int         LOG_CELL = 2,
    parameter bit         WRAP     = 1'b0,
    parameter logic [5:0] FG_RGB   = 6'h3F,
    parameter logic [5:0] BG_RGB   = 6'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  logic        display_on,
    input  logic [7:0]  rule,
    input  logic        seed_rand,
    input  logic        restart,
    output logic [5:0]  rgb,
    output logic [15:0] frame_count
);

    localparam int CELL    = 1 << LOG_CELL;
    localparam int GRID_PX = GRID_W * CELL;
    localparam int PAD_L   = (H_VISIBLE - GRID_PX) / 2;
    localparam int XW      = (GRID_W > 1) ? $clog2(GRID_W) : 1;

    localparam logic [9:0] GX0       = 10'(PAD_L);
    localparam logic [9:0] GX1       = 10'(PAD_L + GRID_PX);
    localparam logic [9:0] LINE_END  = 10'(H_VISIBLE);
    localparam logic [9:0] LAST_LINE = 10'(V_VISIBLE - 1);
    localparam logic [9:0] CELL_M    = 10'(CELL - 1);

    logic [15:0]       lfsr_q;
    logic [GRID_W-1:0] cur_row;
    logic [GRID_W-1:0] frame_row;
    logic [GRID_W-1:0] cur_next;
    logic [GRID_W-1:0] frame_adv;
    logic [GRID_W-1:0] centre_row;
    logic [GRID_W-1:0] rand_row;
    logic [GRID_W-1:0] seed_row;
    logic [7:0]        rule_q;
    logic              restart_pend;
    logic [9:0]        dx;
    logic [XW-1:0]     cell_x;
    logic              in_grid;
    logic              pix_on;
    logic              line_end;
    logic              frame_ev;
    logic              step_ev;

    eca_lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    assign cur_next   = GRID_W'(eca_next(MAX_W'(cur_row), rule_q, WRAP, 8'(GRID_W)));
    assign centre_row = GRID_W'(eca_seed_centre(8'(GRID_W)));
    assign seed_row   = seed_rand ? rand_row : centre_row;

    // Rows wider than the LFSR reuse its 16 bits repeatedly across the grid.
    always_comb begin
        rand_row = '0;
        for (int i = 0; i < GRID_W; i++) begin
            rand_row[i] = lfsr_q[4'(i)];
        end
    end

`ifdef ECA_SCROLL_EN
    assign frame_adv = GRID_W'(eca_next(MAX_W'(frame_row), rule_q, WRAP, 8'(GRID_W)));
`else
    assign frame_adv = frame_row;
`endif

    assign dx      = hpos - GX0;
    assign cell_x  = XW'(dx >> LOG_CELL);
    assign in_grid = display_on && (hpos >= GX0) && (hpos < GX1);
    assign pix_on  = in_grid && cur_row[cell_x];

    // Steps are confined to visible lines so row 0 of every frame is frame_row itself.
    assign line_end = (hpos == LINE_END);
    assign frame_ev = line_end && (vpos == LAST_LINE);
    assign step_ev  = line_end && !frame_ev && (vpos < LAST_LINE) &&
                      ((vpos & CELL_M) == CELL_M);

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb          <= '0;
            frame_count  <= '0;
            rule_q       <= RULE_INIT;
            restart_pend <= 1'b0;
            frame_row    <= centre_row;
            cur_row      <= centre_row;
        end else begin
            rgb          <= pix_on ? FG_RGB : BG_RGB;
            restart_pend <= restart | (restart_pend & ~frame_ev);
            if (frame_ev) begin
                rule_q <= rule;
                if (restart_pend) begin
                    frame_row   <= seed_row;
                    cur_row     <= seed_row;
                    frame_count <= '0;
                end else begin
                    frame_row   <= frame_adv;
                    cur_row     <= frame_adv;
                    frame_count <= frame_count + 16'd1;
                end
            end else if (step_ev) begin
                cur_row <= cur_next;
            end
        end
    end

endmodule
